// File: rtl/cam_capture_rgb444_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cam_capture_rgb444_pkg : shared types and helpers for the capture   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package cam_capture_rgb444_pkg;

    localparam int IMG_W_DEFAULT = 160;
    localparam int IMG_H_DEFAULT = 120;
    localparam int IMG_PIXELS    = IMG_W_DEFAULT * IMG_H_DEFAULT;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_SYNC_ENC  = 2'd1;
    localparam logic [1:0] ST_FRAME_ENC = 2'd2;
    localparam logic [1:0] ST_DONE_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_SYNC  = ST_SYNC_ENC,
        ST_FRAME = ST_FRAME_ENC,
        ST_DONE  = ST_DONE_ENC
    } cap_state_t;

    typedef enum logic {
        PH_HI = 1'b0,
        PH_LO = 1'b1
    } byte_phase_t;

    // RGB444 word layout {R,G,B}
    localparam int RGB444_R_LSB = 8;
    localparam int RGB444_G_LSB = 4;
    localparam int RGB444_B_LSB = 0;

    function automatic logic [11:0] rgb444(input logic [3:0] r,
                                           input logic [3:0] g,
                                           input logic [3:0] b);
        return {r, g, b};
    endfunction

    function automatic int img_pixels(input int w, input int h);
        return w * h;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cam_capture_rgb444_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cam_capture_rgb444_if : camera bus in, frame-buffer write port out  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
interface cam_capture_rgb444_if #(
    parameter int AW = 15,
    parameter int DW = 12
);
    logic          capture_en;
    logic          vsync;
    logic          href;
    logic [7:0]    px_data;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_wr;
    logic          frame_done;
    logic          busy;
    logic          overflow;
    logic          line_err;

    modport master (
        output capture_en, vsync, href, px_data,
        input  mem_addr, mem_data, mem_wr, frame_done, busy, overflow, line_err
    );

    modport slave (
        input  capture_en, vsync, href, px_data,
        output mem_addr, mem_data, mem_wr, frame_done, busy, overflow, line_err
    );
endinterface
`default_nettype wire

// File: rtl/cam_capture_rgb444_rgb565_to_rgb444.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rgb565_to_rgb444 : combinational pack of an RGB565 byte pair        |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module rgb565_to_rgb444
    import cam_capture_rgb444_pkg::*;
(
    input  logic [7:0]  b1,
    input  logic [7:0]  b2,
    output logic [11:0] px
);
    // Keep the top 4 bits of each RGB565 field; G6 straddles the byte boundary.
    assign px = rgb444(b1[7:4], {b1[2:0], b2[7]}, b2[4:1]);

    logic unused_bits;
    assign unused_bits = ^{b1[3], b2[6:5], b2[0]};
endmodule
`default_nettype wire

// File: rtl/cam_capture_rgb444.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cam_capture_rgb444 : OV7670 capture, RGB565->RGB444, buffer writer  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module cam_capture_rgb444
    import cam_capture_rgb444_pkg::*;
#(
    parameter int AW    = 15,
    parameter int DW    = 12,
    parameter int IMG_W = IMG_W_DEFAULT,
    parameter int IMG_H = IMG_H_DEFAULT
)(
    input  logic               clk,
    input  logic               rst,
    cam_capture_rgb444_if.slave bus
);
    localparam logic [AW:0] PIX_LIMIT = (AW+1)'(img_pixels(IMG_W, IMG_H));

    cap_state_t    state;
    byte_phase_t   phase;
    logic          vsync_d;
    logic [7:0]    hi_byte;
    logic [AW-1:0] addr_cnt;
    logic [DW-1:0] wr_data;
    logic          wr_stb;
    logic          done_pulse;
    logic          busy_reg;
    logic          ovf_flag;
    logic          lerr_flag;
    logic [11:0]   packed_px;
    logic          vs_rise;
    logic          vs_fall;

    rgb565_to_rgb444 u_pack (
        .b1 (hi_byte),
        .b2 (bus.px_data),
        .px (packed_px)
    );

    assign vs_rise = bus.vsync & ~vsync_d;
    assign vs_fall = ~bus.vsync & vsync_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            phase      <= PH_HI;
            vsync_d    <= 1'b0;
            hi_byte    <= '0;
            addr_cnt   <= '0;
            wr_data    <= '0;
            wr_stb     <= 1'b0;
            done_pulse <= 1'b0;
            busy_reg   <= 1'b0;
            ovf_flag   <= 1'b0;
            lerr_flag  <= 1'b0;
        end else begin
            vsync_d    <= bus.vsync;
            wr_stb     <= 1'b0;
            done_pulse <= 1'b0;
            // Address advances the cycle after each write so it is stable under mem_wr.
            if (wr_stb) begin
                addr_cnt <= addr_cnt + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    phase <= PH_HI;
                    if (bus.capture_en && bus.vsync) begin
                        state <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    phase <= PH_HI;
                    if (vs_fall) begin
                        addr_cnt  <= '0;
                        ovf_flag  <= 1'b0;
                        lerr_flag <= 1'b0;
                        busy_reg  <= 1'b1;
                        state     <= ST_FRAME;
                    end
                end
                ST_FRAME: begin
                    if (vs_rise) begin
                        // Any half-received pixel is dropped when the frame closes.
                        phase      <= PH_HI;
                        busy_reg   <= 1'b0;
                        done_pulse <= 1'b1;
                        state      <= ST_DONE;
                    end else if (bus.href) begin
                        if (phase == PH_HI) begin
                            hi_byte <= bus.px_data;
                            phase   <= PH_LO;
                        end else begin
                            phase <= PH_HI;
                            if ({1'b0, addr_cnt} < PIX_LIMIT) begin
                                wr_stb  <= 1'b1;
                                wr_data <= DW'(packed_px);
                            end else begin
                                ovf_flag <= 1'b1;
                            end
                        end
                    end else begin
                        if (phase == PH_LO) begin
                            lerr_flag <= 1'b1;
                        end
                        phase <= PH_HI;
                    end
                end
                ST_DONE: begin
                    state <= bus.capture_en ? ST_SYNC : ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_addr   = addr_cnt;
    assign bus.mem_data   = wr_data;
    assign bus.mem_wr     = wr_stb;
    assign bus.frame_done = done_pulse;
    assign bus.busy       = busy_reg;
    assign bus.overflow   = ovf_flag;
    assign bus.line_err   = lerr_flag;
endmodule
`default_nettype wire

// File: tb/tb_cam_capture_rgb444.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cam_capture_rgb444 : scoreboard bench for cam_capture_rgb444     |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_cam_capture_rgb444;
    localparam int AW    = 15;
    localparam int DW    = 12;
    localparam int IMG_W = 16;
    localparam int IMG_H = 4;
    localparam int PIX   = IMG_W * IMG_H;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   wr_cnt = 0;
    int   done_cnt = 0;
    int   model_addr = 0;

    cam_capture_rgb444_if #(.AW(AW), .DW(DW)) bus ();

    cam_capture_rgb444 #(.AW(AW), .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Monitor: every write must match the head of the expected queue.
    always @(negedge clk) begin
        exp_t e;
        if (bus.frame_done === 1'b1) done_cnt++;
        if (bus.mem_wr === 1'b1) begin
            wr_cnt++;
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write addr=%0d data=%h required=no write", bus.mem_addr, bus.mem_data);
            end else begin
                e = sb.pop_front();
                if (bus.mem_addr !== e.addr || bus.mem_data !== e.data) begin
                    fails++;
                    $display("FAIL write actual addr=%0d data=%h required addr=%0d data=%h",
                             bus.mem_addr, bus.mem_data, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic drive(input logic v, input logic h, input logic [7:0] d);
        @(posedge clk);
        #1;
        bus.vsync   = v;
        bus.href    = h;
        bus.px_data = d;
    endtask

    task automatic send_pixel(input logic [7:0] b1, input logic [7:0] b2,
                              input logic [11:0] px, input bit expect_wr);
        exp_t e;
        if (expect_wr) begin
            if (model_addr < PIX) begin
                e.addr = AW'(model_addr);
                e.data = px;
                sb.push_back(e);
                model_addr++;
            end
        end
        drive(1'b0, 1'b1, b1);
        drive(1'b0, 1'b1, b2);
    endtask

    task automatic gap();
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic frame_start();
        repeat (3) drive(1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        model_addr = 0;
    endtask

    task automatic frame_end();
        repeat (3) drive(1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        int wr_base;
        int done_base;
        bus.capture_en = 1'b0;
        bus.vsync      = 1'b0;
        bus.href       = 1'b0;
        bus.px_data    = 8'h00;

        // Reset held with random bus activity: outputs stay zero.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            bus.capture_en = 1'($urandom);
            bus.vsync      = 1'($urandom);
            bus.href       = 1'($urandom);
            bus.px_data    = 8'($urandom);
            @(negedge clk);
            check("reset_outputs", {bus.mem_addr, bus.mem_data, bus.mem_wr, bus.frame_done,
                                    bus.busy, bus.overflow, bus.line_err}, 32'd0);
        end
        @(posedge clk);
        #1;
        bus.capture_en = 1'b0;
        bus.vsync      = 1'b0;
        bus.href       = 1'b0;
        rst            = 1'b0;
        bus.capture_en = 1'b1;

        // Full frame of 0xF8,0x00 pixels.
        wr_base = wr_cnt;
        frame_start();
        check("busy_in_frame", 32'(bus.busy), 32'd1);
        for (int l = 0; l < IMG_H; l++) begin
            for (int p = 0; p < IMG_W; p++) send_pixel(8'hF8, 8'h00, 12'hF00, 1'b1);
            gap();
        end
        frame_end();
        check("full_writes", 32'(wr_cnt - wr_base), 32'(PIX));
        check("full_done", 32'(done_cnt), 32'd1);
        check("full_overflow", 32'(bus.overflow), 32'd0);
        check("full_addr", 32'(bus.mem_addr), 32'(PIX));
        check("full_busy_after", 32'(bus.busy), 32'd0);
        check("full_sb_empty", 32'(sb.size()), 32'd0);

        // Packing vectors, odd-length line, then a line that must restart on HI.
        frame_start();
        send_pixel(8'h07, 8'hE0, 12'h0F0, 1'b1);
        send_pixel(8'h00, 8'h1F, 12'h00F, 1'b1);
        send_pixel(8'hFF, 8'hFF, 12'hFFF, 1'b1);
        gap();
        check("line_err_clean", 32'(bus.line_err), 32'd0);
        send_pixel(8'h12, 8'h34, 12'h14A, 1'b1);
        send_pixel(8'h56, 8'h78, 12'h5CC, 1'b1);
        drive(1'b0, 1'b1, 8'h9A);
        gap();
        check("line_err_set", 32'(bus.line_err), 32'd1);
        send_pixel(8'hAB, 8'hCD, 12'hA76, 1'b1);
        gap();
        frame_end();
        check("pack_addr", 32'(bus.mem_addr), 32'd6);
        check("pack_done", 32'(done_cnt), 32'd2);
        check("line_err_sticky", 32'(bus.line_err), 32'd1);
        check("pack_sb_empty", 32'(sb.size()), 32'd0);

        // Overflow: one pixel more than the buffer holds.
        wr_base = wr_cnt;
        frame_start();
        check("line_err_cleared", 32'(bus.line_err), 32'd0);
        for (int l = 0; l < IMG_H; l++) begin
            for (int p = 0; p < IMG_W; p++) send_pixel(8'hF8, 8'h00, 12'hF00, 1'b1);
            gap();
        end
        check("no_overflow_at_limit", 32'(bus.overflow), 32'd0);
        send_pixel(8'hFF, 8'hFF, 12'hFFF, 1'b1);
        gap();
        frame_end();
        check("ovf_writes", 32'(wr_cnt - wr_base), 32'(PIX));
        check("ovf_flag", 32'(bus.overflow), 32'd1);
        check("ovf_addr_sat", 32'(bus.mem_addr), 32'(PIX));

        // Reset mid-frame, then a late vsync rise with a byte in flight.
        frame_start();
        check("ovf_cleared", 32'(bus.overflow), 32'd0);
        for (int p = 0; p < 10; p++) send_pixel(8'h07, 8'hE0, 12'h0F0, 1'b1);
        drive(1'b0, 1'b1, 8'hF8);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 8'(8'h40 + i));
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) drive(1'b0, 1'(i % 3 != 2), 8'(8'h80 + i));
        gap();
        check("post_rst_idle", 32'(bus.busy), 32'd0);
        done_base = done_cnt;
        frame_start();
        send_pixel(8'h00, 8'h1F, 12'h00F, 1'b1);
        send_pixel(8'hFF, 8'hFF, 12'hFFF, 1'b1);
        drive(1'b0, 1'b1, 8'hF8);
        drive(1'b1, 1'b1, 8'h00);
        frame_end();
        check("resume_addr", 32'(bus.mem_addr), 32'd2);
        check("resume_done", 32'(done_cnt - done_base), 32'd1);
        check("resume_sb_empty", 32'(sb.size()), 32'd0);

        // capture_en dropped mid-frame: frame finishes, next one is ignored.
        done_base = done_cnt;
        frame_start();
        send_pixel(8'hF8, 8'h00, 12'hF00, 1'b1);
        bus.capture_en = 1'b0;
        send_pixel(8'h07, 8'hE0, 12'h0F0, 1'b1);
        gap();
        frame_end();
        check("stop_done", 32'(done_cnt - done_base), 32'd1);
        check("stop_addr", 32'(bus.mem_addr), 32'd2);
        frame_start();
        check("stop_idle_busy", 32'(bus.busy), 32'd0);
        for (int p = 0; p < 3; p++) send_pixel(8'hFF, 8'hFF, 12'hFFF, 1'b0);
        gap();
        frame_end();
        gap();
        check("stop_no_done", 32'(done_cnt - done_base), 32'd1);
        check("stop_addr_held", 32'(bus.mem_addr), 32'd2);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
